// File: rtl/comma_sync_pkg.sv
// comma_sync_pkg: shared types and constants for the comma aligner.
// Optional statistics outputs are enabled by defining COMMA_SYNC_STATS_EN.
package comma_sync_pkg;

    // Alignment state machine encoding
    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        CONFIRM = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    // K28.5 in both running-disparity forms
    localparam logic [9:0] K28_5_RDN = 10'b0011111010;
    localparam logic [9:0] K28_5_RDP = 10'b1100000101;

    // Larger of two integers, used to size the lock/loss counters
    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/comma_sync_if.sv
// comma_sync_if: raw word input, aligned symbol output and lock status.
// realign_cnt / comma_err exist only when COMMA_SYNC_STATS_EN is defined.
//
// Handshake: a word is accepted on every rising clock edge where in_valid is 1;
// there is no backpressure. out_valid is 1 for exactly one cycle per accepted
// word, one cycle after acceptance; out_data/out_comma are only meaningful
// while out_valid is 1 and hold their last value otherwise.
interface comma_sync_if
    import comma_sync_pkg::*;
#(
    parameter int W = 10
) ();
    localparam int OW = $clog2(W);

    logic [W-1:0]  in_data;
    logic          in_valid;
    logic [W-1:0]  out_data;
    logic          out_valid;
    logic          out_comma;
    logic [OW-1:0] offset;
    logic          locked;
    logic          slip;
    state_t        dbg_state;
`ifdef COMMA_SYNC_STATS_EN
    logic [15:0]   realign_cnt;
    logic          comma_err;
`endif

`ifdef COMMA_SYNC_STATS_EN
    modport master (
        output in_data, in_valid,
        input  out_data, out_valid, out_comma, offset, locked, slip, dbg_state,
        input  realign_cnt, comma_err
    );
    modport slave (
        input  in_data, in_valid,
        output out_data, out_valid, out_comma, offset, locked, slip, dbg_state,
        output realign_cnt, comma_err
    );
`else
    modport master (
        output in_data, in_valid,
        input  out_data, out_valid, out_comma, offset, locked, slip, dbg_state
    );
    modport slave (
        input  in_data, in_valid,
        output out_data, out_valid, out_comma, offset, locked, slip, dbg_state
    );
`endif

endinterface

// File: rtl/comma_sync_detect.sv
// comma_detect: combinational comma search over a 2W-1 bit window.
// Reports every offset holding a comma, whether exactly one matched, and
// the index of the match. Kept lane-agnostic so several lanes can share it.
module comma_detect
    import comma_sync_pkg::*;
#(
    parameter int           W       = 10,
    parameter logic [W-1:0] COMMA_P = W'(K28_5_RDN),
    parameter logic [W-1:0] COMMA_N = W'(K28_5_RDP)
) (
    input  logic [2*W-2:0]         i_window,
    output logic [W-1:0]           o_match,
    output logic                   o_one_hot,
    output logic [$clog2(W)-1:0]   o_k
);
    localparam int OW = $clog2(W);

    // Compare each of the W candidate slices against both comma forms
    always_comb begin
        o_match = '0;
        for (int i = 0; i < W; i++) begin
            if ((i_window[i +: W] == COMMA_P) || (i_window[i +: W] == COMMA_N)) begin
                o_match[i] = 1'b1;
            end
        end
    end

    // Encode the matching index; only trusted when o_one_hot is set
    always_comb begin
        o_k = '0;
        for (int i = 0; i < W; i++) begin
            if (o_match[i]) begin
                o_k = OW'(i);
            end
        end
    end

    assign o_one_hot = (o_match != '0) && ((o_match & (o_match - 1'b1)) == '0);

endmodule

// File: rtl/comma_sync.sv
// comma_sync: comma-based symbol aligner with hysteresis lock/unlock.
// Optional realign_cnt / comma_err outputs under COMMA_SYNC_STATS_EN.
module comma_sync
    import comma_sync_pkg::*;
#(
    parameter int           W        = 10,
    parameter logic [W-1:0] COMMA_P  = W'(K28_5_RDN),
    parameter logic [W-1:0] COMMA_N  = W'(K28_5_RDP),
    parameter int           LOCK_CNT = 3,
    parameter int           LOSS_CNT = 4
) (
    input  logic        clk,
    input  logic        reset,
    comma_sync_if.slave bus
);
    localparam int OW = $clog2(W);
    localparam int CW = $clog2(max2(LOCK_CNT, LOSS_CNT) + 1);
    localparam logic [CW-1:0] LOCK_C = CW'(LOCK_CNT);
    localparam logic [CW-1:0] LOSS_C = CW'(LOSS_CNT);

    state_t          r_state, w_next_state;
    logic [W-2:0]    r_last;
    logic [OW-1:0]   r_offset, w_offset_nxt;
    logic [CW-1:0]   r_good, w_good_nxt, w_good_inc;
    logic [CW-1:0]   r_bad, w_bad_nxt, w_bad_inc;
    logic            r_slip, w_slip_nxt;
    logic            w_err_nxt;
    logic [W-1:0]    r_out_data;
    logic            r_out_valid, r_out_comma;

    logic [2*W-2:0]  w_window;
    logic [W-1:0]    w_match;
    logic            w_one_hot;
    logic [OW-1:0]   w_k;
    logic            w_comma, w_aligned;
    logic [W-1:0]    w_out_word;

    // Previous word sits above the current one; offset 0 is the raw word
    assign w_window   = {r_last, bus.in_data};
    assign w_out_word = w_window[r_offset +: W];
    assign w_comma    = bus.in_valid && w_one_hot;
    assign w_aligned  = w_match[r_offset];
    assign w_good_inc = r_good + 1'b1;
    assign w_bad_inc  = r_bad + 1'b1;

    comma_detect #(
        .W       (W),
        .COMMA_P (COMMA_P),
        .COMMA_N (COMMA_N)
    ) u_detect (
        .i_window  (w_window),
        .o_match   (w_match),
        .o_one_hot (w_one_hot),
        .o_k       (w_k)
    );

    // State register; only accepted words can move the state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= HUNT;
        end else if (bus.in_valid) begin
            r_state <= w_next_state;
        end
    end

    // Next-state: lock after LOCK_CNT aligned commas, drop after LOSS_CNT misaligned
    always_comb begin
        w_next_state = r_state;
        if (w_comma) begin
            case (r_state)
                HUNT:    w_next_state = (LOCK_CNT == 1) ? LOCKED : CONFIRM;
                CONFIRM: if (w_aligned && (w_good_inc >= LOCK_C)) w_next_state = LOCKED;
                LOCKED:  if (!w_aligned && (w_bad_inc >= LOSS_C)) w_next_state = HUNT;
                default: w_next_state = HUNT;
            endcase
        end
    end

    // Counter, offset and pulse updates driven by the current state
    always_comb begin
        w_offset_nxt = r_offset;
        w_good_nxt   = r_good;
        w_bad_nxt    = r_bad;
        w_slip_nxt   = 1'b0;
        w_err_nxt    = 1'b0;
        if (w_comma) begin
            case (r_state)
                HUNT: begin
                    w_offset_nxt = w_k;
                    w_good_nxt   = CW'(1);
                    w_slip_nxt   = (w_k != r_offset);
                end
                CONFIRM: begin
                    if (w_aligned) begin
                        w_good_nxt = w_good_inc;
                        if (w_good_inc >= LOCK_C) w_bad_nxt = '0;
                    end else begin
                        w_offset_nxt = w_k;
                        w_good_nxt   = CW'(1);
                        w_slip_nxt   = 1'b1;
                    end
                end
                LOCKED: begin
                    if (w_aligned) begin
                        w_bad_nxt = '0;
                    end else begin
                        w_err_nxt = 1'b1;
                        if (w_bad_inc >= LOSS_C) begin
                            w_good_nxt = '0;
                            w_bad_nxt  = '0;
                        end else begin
                            w_bad_nxt = w_bad_inc;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath registers; idle cycles hold all but out_valid and slip
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last      <= '0;
            r_offset    <= '0;
            r_good      <= '0;
            r_bad       <= '0;
            r_slip      <= 1'b0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_comma <= 1'b0;
        end else begin
            r_out_valid <= bus.in_valid;
            r_slip      <= w_slip_nxt;
            if (bus.in_valid) begin
                r_last      <= bus.in_data[W-2:0];
                r_offset    <= w_offset_nxt;
                r_good      <= w_good_nxt;
                r_bad       <= w_bad_nxt;
                r_out_data  <= w_out_word;
                r_out_comma <= (w_out_word == COMMA_P) || (w_out_word == COMMA_N);
            end
        end
    end

    assign bus.out_data  = r_out_data;
    assign bus.out_valid = r_out_valid;
    assign bus.out_comma = r_out_comma;
    assign bus.offset    = r_offset;
    assign bus.locked    = (r_state == LOCKED);
    assign bus.slip      = r_slip;
    assign bus.dbg_state = r_state;

`ifdef COMMA_SYNC_STATS_EN
    logic [15:0] r_realign_cnt;
    logic        r_comma_err;

    // Saturating count of lock losses plus a pulse per misaligned comma
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_realign_cnt <= '0;
            r_comma_err   <= 1'b0;
        end else begin
            r_comma_err <= w_err_nxt;
            if (bus.in_valid && (r_state == LOCKED) && (w_next_state == HUNT)
                && (r_realign_cnt != 16'hFFFF)) begin
                r_realign_cnt <= r_realign_cnt + 16'd1;
            end
        end
    end

    assign bus.realign_cnt = r_realign_cnt;
    assign bus.comma_err   = r_comma_err;
`else
    logic w_err_unused;
    assign w_err_unused = w_err_nxt;
`endif

endmodule

// File: tb/tb_comma_sync.sv
// tb_comma_sync: directed and randomized checks of comma_sync against a
// behavioural model of the alignment rules.
module tb_comma_sync;
    localparam int W = 10;
    localparam int OW = $clog2(W);
    localparam int LOCK_CNT = 3;
    localparam int LOSS_CNT = 4;
    localparam logic [W-1:0] CP = 10'b0011111010;
    localparam logic [W-1:0] CN = 10'b1100000101;
    localparam logic [W-1:0] FILL = 10'b0101010101;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   slip_seen = 0;

    comma_sync_if #(.W(W)) bus ();

    comma_sync #(
        .W(W), .COMMA_P(CP), .COMMA_N(CN), .LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Behavioural model: 0 = hunting, 1 = confirming, 2 = locked
    logic [W-1:0] m_last;
    int m_state, m_off, m_good, m_bad, m_realign;
    logic [W-1:0] exp_data;
    logic exp_valid, exp_comma, exp_slip, exp_err;

    task automatic model_reset();
        m_last = '0; m_state = 0; m_off = 0; m_good = 0; m_bad = 0; m_realign = 0;
        exp_data = '0; exp_valid = 0; exp_comma = 0; exp_slip = 0; exp_err = 0;
    endtask

    // Present one word for one cycle and advance the model
    task automatic send(input logic [W-1:0] d, input logic v);
        logic [2*W-2:0] win;
        int n, k;
        bus.in_data = d;
        bus.in_valid = v;
        exp_valid = v;
        exp_slip = 0;
        exp_err = 0;
        if (v) begin
            win = {m_last[W-2:0], d};
            n = 0; k = 0;
            for (int i = 0; i < W; i++) begin
                if (win[i +: W] == CP || win[i +: W] == CN) begin n++; k = i; end
            end
            exp_data = win[m_off +: W];
            exp_comma = (exp_data == CP) || (exp_data == CN);
            if (n == 1) begin
                if (m_state == 0) begin
                    exp_slip = (k != m_off); m_off = k; m_good = 1;
                    m_state = (LOCK_CNT == 1) ? 2 : 1;
                end else if (m_state == 1) begin
                    if (k == m_off) begin
                        m_good++;
                        if (m_good >= LOCK_CNT) begin m_state = 2; m_bad = 0; end
                    end else begin
                        m_off = k; m_good = 1; exp_slip = 1;
                    end
                end else begin
                    if (k == m_off) m_bad = 0;
                    else begin
                        exp_err = 1; m_bad++;
                        if (m_bad >= LOSS_CNT) begin
                            m_state = 0; m_good = 0; m_bad = 0;
                            if (m_realign < 65535) m_realign++;
                        end
                    end
                end
            end
            m_last = d;
        end
        @(posedge clk);
        #1;
        slip_seen += int'(bus.slip);
    endtask

    // Two valid words placing pattern pat at window offset k in the second
    task automatic send_comma(input int k, input logic [W-1:0] pat,
                              input logic [W-1:0] fa, input logic [W-1:0] fb);
        logic [W-1:0] mask, prev, cur;
        mask = (W'(1) << k) - W'(1);
        prev = (fa & ~mask) | (pat >> (W - k));
        cur  = (fb & mask) | (pat << k);
        send(prev, 1'b1);
        send(cur, 1'b1);
    endtask

    task automatic do_reset();
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (bus.out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid got %0b exp 0", bus.out_valid); end
        n_checks++; if (bus.out_data !== '0) begin n_errors++; $display("FAIL reset_out_data got %h exp 0", bus.out_data); end
        n_checks++; if (bus.locked !== 1'b0) begin n_errors++; $display("FAIL reset_locked got %0b exp 0", bus.locked); end
        n_checks++; if (bus.offset !== '0) begin n_errors++; $display("FAIL reset_offset got %0d exp 0", bus.offset); end
        n_checks++; if (bus.slip !== 1'b0 || bus.out_comma !== 1'b0) begin n_errors++; $display("FAIL reset_pulses slip %0b comma %0b exp 0", bus.slip, bus.out_comma); end
    endtask

    task automatic test_lock();
        do_reset();
        slip_seen = 0;
        for (int j = 0; j < 3; j++) begin
            send_comma(3, CP, FILL, FILL);
            n_checks++; if (bus.locked !== (j == 2)) begin n_errors++; $display("FAIL lock_locked comma %0d got %0b exp %0b", j, bus.locked, j == 2); end
            n_checks++; if (bus.out_comma !== (j != 0)) begin n_errors++; $display("FAIL lock_out_comma comma %0d got %0b exp %0b", j, bus.out_comma, j != 0); end
            n_checks++; if (bus.out_data !== exp_data) begin n_errors++; $display("FAIL lock_out_data got %h exp %h", bus.out_data, exp_data); end
            send(FILL, 1'b1);
        end
        n_checks++; if (bus.offset !== OW'(3)) begin n_errors++; $display("FAIL lock_offset got %0d exp 3", bus.offset); end
        n_checks++; if (slip_seen != 1) begin n_errors++; $display("FAIL lock_slip_count got %0d exp 1", slip_seen); end
    endtask

    task automatic test_confirm_restart();
        do_reset();
        send_comma(3, CP, FILL, FILL);
        send_comma(3, CN, FILL, FILL);
        send_comma(6, CP, FILL, FILL);
        n_checks++; if (bus.slip !== 1'b1 || bus.offset !== OW'(6)) begin n_errors++; $display("FAIL restart_slip slip %0b offset %0d exp 1 6", bus.slip, bus.offset); end
        n_checks++; if (bus.locked !== 1'b0) begin n_errors++; $display("FAIL restart_early_lock got %0b exp 0", bus.locked); end
        send_comma(6, CP, FILL, FILL);
        n_checks++; if (bus.locked !== 1'b0) begin n_errors++; $display("FAIL restart_second got %0b exp 0", bus.locked); end
        send_comma(6, CN, FILL, FILL);
        n_checks++; if (bus.locked !== 1'b1 || bus.offset !== OW'(6)) begin n_errors++; $display("FAIL restart_lock locked %0b offset %0d exp 1 6", bus.locked, bus.offset); end
    endtask

    task automatic test_loss();
        do_reset();
        for (int j = 0; j < 3; j++) send_comma(3, CP, FILL, FILL);
        for (int j = 0; j < 7; j++) begin
            send_comma((j == 3) ? 3 : 5, CP, FILL, FILL);
            send(FILL, 1'b1);
        end
        n_checks++; if (bus.locked !== 1'b1) begin n_errors++; $display("FAIL loss_hysteresis got %0b exp 1", bus.locked); end
        send_comma(5, CP, FILL, FILL);
        n_checks++; if (bus.locked !== 1'b0) begin n_errors++; $display("FAIL loss_unlock got %0b exp 0", bus.locked); end
        n_checks++; if (bus.offset !== OW'(3)) begin n_errors++; $display("FAIL loss_offset_kept got %0d exp 3", bus.offset); end
    endtask

    task automatic test_double_comma();
        logic [W-1:0] hi;
        do_reset();
        send_comma(3, CP, FILL, FILL);
        hi = CP >> 1;
        send(hi, 1'b1);
        send(CP, 1'b1);
        n_checks++; if (bus.offset !== OW'(3) || bus.slip !== 1'b0) begin n_errors++; $display("FAIL double_held offset %0d slip %0b exp 3 0", bus.offset, bus.slip); end
        send(FILL, 1'b1);
        send_comma(3, CP, FILL, FILL);
        n_checks++; if (bus.locked !== 1'b0) begin n_errors++; $display("FAIL double_count got %0b exp 0", bus.locked); end
        send_comma(3, CP, FILL, FILL);
        n_checks++; if (bus.locked !== 1'b1) begin n_errors++; $display("FAIL double_lock got %0b exp 1", bus.locked); end
    endtask

    task automatic test_idle();
        do_reset();
        send_comma(3, CP, FILL, FILL);
        send_comma(3, CP, FILL, FILL);
        for (int j = 0; j < 5; j++) begin
            send(FILL, 1'b0);
            n_checks++; if (bus.out_valid !== 1'b0 || bus.slip !== 1'b0) begin n_errors++; $display("FAIL idle_valid cycle %0d valid %0b slip %0b exp 0 0", j, bus.out_valid, bus.slip); end
            n_checks++; if (bus.locked !== 1'b0 || bus.offset !== OW'(3)) begin n_errors++; $display("FAIL idle_hold locked %0b offset %0d exp 0 3", bus.locked, bus.offset); end
        end
        send_comma(3, CP, FILL, FILL);
        n_checks++; if (bus.locked !== 1'b1 || bus.out_valid !== 1'b1) begin n_errors++; $display("FAIL idle_resume locked %0b valid %0b exp 1 1", bus.locked, bus.out_valid); end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int j = 0; j < 3; j++) send_comma(4, CP, FILL, FILL);
        bus.in_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        n_checks++; if (bus.locked !== 1'b0 || bus.offset !== '0) begin n_errors++; $display("FAIL areset_state locked %0b offset %0d exp 0 0", bus.locked, bus.offset); end
        n_checks++; if (bus.out_valid !== 1'b0 || bus.out_data !== '0 || bus.out_comma !== 1'b0) begin n_errors++; $display("FAIL areset_out valid %0b data %h comma %0b exp 0", bus.out_valid, bus.out_data, bus.out_comma); end
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        send_comma(5, CP, FILL, FILL);
        n_checks++; if (bus.locked !== 1'b0 || bus.offset !== OW'(5) || bus.slip !== 1'b1) begin n_errors++; $display("FAIL areset_hunt locked %0b offset %0d slip %0b exp 0 5 1", bus.locked, bus.offset, bus.slip); end
    endtask

    task automatic test_random();
        logic [W-1:0] words[2];
        logic vals[2];
        logic [W-1:0] mask;
        int nw, k, cur_k, r;
        do_reset();
        cur_k = 2;
        for (int it = 0; it < 300; it++) begin
            r = $urandom_range(0, 9);
            nw = 1;
            words[0] = W'($urandom);
            vals[0] = (r != 9);
            if (r < 4) begin
                if ($urandom_range(0, 5) == 0) cur_k = $urandom_range(0, W - 1);
                k = ($urandom_range(0, 7) == 0) ? $urandom_range(0, W - 1) : cur_k;
                mask = (W'(1) << k) - W'(1);
                words[0] = (W'($urandom) & ~mask) | ((r[0] ? CP : CN) >> (W - k));
                words[1] = (W'($urandom) & mask) | ((r[0] ? CP : CN) << k);
                vals[0] = 1'b1; vals[1] = 1'b1;
                nw = 2;
            end
            for (int j = 0; j < nw; j++) begin
                send(words[j], vals[j]);
                n_checks++; if (bus.out_valid !== exp_valid) begin n_errors++; $display("FAIL rnd_valid it %0d got %0b exp %0b", it, bus.out_valid, exp_valid); end
                n_checks++; if (bus.out_data !== exp_data) begin n_errors++; $display("FAIL rnd_data it %0d got %h exp %h", it, bus.out_data, exp_data); end
                n_checks++; if (bus.out_comma !== exp_comma) begin n_errors++; $display("FAIL rnd_comma it %0d got %0b exp %0b", it, bus.out_comma, exp_comma); end
                n_checks++; if (bus.offset !== OW'(m_off)) begin n_errors++; $display("FAIL rnd_offset it %0d got %0d exp %0d", it, bus.offset, m_off); end
                n_checks++; if (bus.locked !== (m_state == 2)) begin n_errors++; $display("FAIL rnd_locked it %0d got %0b exp %0b", it, bus.locked, m_state == 2); end
                n_checks++; if (bus.slip !== exp_slip) begin n_errors++; $display("FAIL rnd_slip it %0d got %0b exp %0b", it, bus.slip, exp_slip); end
`ifdef COMMA_SYNC_STATS_EN
                n_checks++; if (bus.comma_err !== exp_err) begin n_errors++; $display("FAIL rnd_comma_err it %0d got %0b exp %0b", it, bus.comma_err, exp_err); end
                n_checks++; if (bus.realign_cnt !== 16'(m_realign)) begin n_errors++; $display("FAIL rnd_realign it %0d got %0d exp %0d", it, bus.realign_cnt, m_realign); end
`endif
            end
        end
    endtask

    initial begin
        bus.in_data = '0;
        bus.in_valid = 1'b0;
        model_reset();
        test_reset();
        test_lock();
        test_confirm_restart();
        test_loss();
        test_double_comma();
        test_idle();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/comma_sync.md
Name: comma_sync

Overview:
- Parametrised symbol aligner and sync state machine for 8b/10b-style serial receive paths. Sits between the deserialiser word output and the symbol decoder.
- Searches a window spanning two consecutive input words for comma patterns and qualifies alignment over several commas. Outputs word-aligned symbols plus lock status, declaring loss of sync after repeated misaligned commas.
- Replaces one-shot offset detection with hysteresis-based lock/unlock and an internal barrel shift.

Parameters:
- W, 10, symbol/word width in bits (>= 4)
- COMMA_P, 10'b0011111010, comma pattern, RD- form (W bits)
- COMMA_N, 10'b1100000101, comma pattern, RD+ form (W bits)
- LOCK_CNT, 3, consecutive commas at the same offset required to lock (>= 1)
- LOSS_CNT, 4, consecutive misaligned commas while locked that cause loss of lock (>= 1)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- in_data  in  W  raw deserialised word
- in_valid  in  1  in_data valid this cycle
- out_data  out  W  aligned symbol
- out_valid  out  1  out_data valid
- out_comma  out  1  out_data equals COMMA_P or COMMA_N
- offset  out  $clog2(W)  current applied bit offset
- locked  out  1  alignment locked
- slip  out  1  one-cycle pulse when the applied offset changes

Behaviour:
- Reset (async assert, sync release): all outputs 0; last_word = 0; state HUNT; counters 0.
- Only cycles with in_valid = 1 advance state; idle cycles hold everything except out_valid and slip, which go to 0.
- last_word[W-2:0] <= in_data[W-2:0] on each valid word.
- Search window is {last_word, in_data}, 2W-1 bits. match[i] = (window[i+:W] == COMMA_P or COMMA_N), for i = 0..W-1.
- A comma event requires exactly one set bit in match; its index is k. Zero or multiple set bits count as no comma.
- Output path:
  - out_data <= window[offset_reg+:W], registered.
  - out_valid <= in_valid; 1-cycle latency.
  - The offset used is the value held before this cycle's update, so a new offset affects the next valid word.
- out_comma <= (out_data next value equals COMMA_P or COMMA_N).
- State machine:
  - HUNT:
    - locked = 0.
    - Comma at k: offset_reg <= k; good_cnt <= 1; slip pulses if k != offset_reg.
    - If LOCK_CNT == 1, go to LOCKED; else go to CONFIRM.
  - CONFIRM:
    - Comma at k == offset_reg: good_cnt++. On reaching LOCK_CNT, go to LOCKED and clear bad_cnt.
    - Comma at k != offset_reg: offset_reg <= k; good_cnt <= 1; slip; stay in CONFIRM.
    - No comma: hold.
  - LOCKED:
    - locked = 1.
    - Comma at offset_reg: bad_cnt <= 0.
    - Comma at k != offset_reg: bad_cnt++. On reaching LOSS_CNT, go to HUNT with good_cnt = 0 and bad_cnt = 0; offset_reg is retained.
    - No comma: hold.
- locked is registered and asserts on the cycle after the qualifying word is accepted.
- Counters are $clog2(max(LOCK_CNT, LOSS_CNT) + 1) bits and never wrap.
- Reset mid-lock returns to HUNT immediately; no partial output word is emitted.

Optional Feature:
- Macro: COMMA_SYNC_STATS_EN.
- With the macro defined:
  - Adds output realign_cnt [15:0], a saturating count of LOCKED->HUNT transitions; reset 0.
  - Adds output comma_err, a 1-cycle pulse on each misaligned comma while LOCKED.
- Without the macro: those ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package comma_sync_pkg:
  - state enum (HUNT, CONFIRM, LOCKED)
  - K28_5_RDN / K28_5_RDP constants used as parameter defaults
- Sub-module comma_detect (combinational):
  - window in
  - match vector, one-hot-valid flag and encoded index k out
  - shared with future multi-lane versions

Test Plan:
- Reset, then K28.5 (0011111010) placed at offset 3 in 3 consecutive words, with data words between -> locked = 1 one cycle after the 3rd comma; offset = 3; out_comma = 1 on aligned commas; slip pulses exactly once.
- CONFIRM with commas at offset 3, 3, then offset 6 -> offset = 6; slip pulse; good_cnt restarts; lock only after 2 further commas at offset 6.
- Locked at offset 3, then 3 misaligned commas, 1 aligned, 3 misaligned -> stays locked. A 4th consecutive misaligned comma -> locked = 0 on the next cycle.
- Input window containing both COMMA_P and COMMA_N at two offsets -> treated as no comma; state and offset unchanged.
- in_valid deasserted for 5 cycles mid-CONFIRM -> out_valid = 0 for those cycles; counters hold; lock proceeds on resumption.
- Async reset asserted between clock edges while locked -> all outputs 0 immediately; HUNT after release.
